data_memory_unit: RTL and testbench
===================================

Name: data_memory_unit

Overview:
- Data memory that feeds the load-data (dataDM) operand path into the ALU B-operand select.
- Accepts load/store requests from the CPU datapath through a valid/ready handshake.
- Single-port synchronous RAM with a one-entry store buffer and store-to-load forwarding.
- After every reset, runs a self-clear sequence so all locations read as zero.

Parameters:
- DATA_W, 8, data word width (matches the datapath operand width).
- ADDR_W, 8, address width.
- DEPTH, 2**ADDR_W, number of words; always a power of two.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  one-cycle pulse: rsp_data holds a new load result.
- rsp_data  output  DATA_W  load result, i.e. the dataDM value; held between responses.
- idle  output  1  state is RUN and the store buffer is empty.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - state = INIT, clear counter = 0, wb_valid = 0.
  - rsp_valid = 0, rsp_data = 0, req_ready = 0, idle = 0.
  - Any pending buffered store is discarded.
- Reset asserted mid-operation (including during INIT) restarts the clear from address 0.
- INIT state:
  - req_ready = 0; requests are ignored.
  - Each cycle writes 0 to RAM[cnt], then increments cnt.
  - After writing DEPTH-1, moves to RUN. cnt wraps to 0 and is not used again until the next reset.
  - req_ready first reads 1 exactly DEPTH cycles after the first rising edge with reset low.
- RUN state: req_ready = 1 every cycle. A request is accepted when req_valid && req_ready.
- RAM port arbitration (one access per cycle):
  - If an accepted load exists, the port serves the read.
  - Otherwise, if wb_valid, the port drains the buffer into RAM[wb_addr] and clears wb_valid.
  - An accepted store in the same cycle loads the buffer. It is written after any drain in the same edge, so wb_valid stays 1.
- Stores:
  - Always accepted in RUN; enter the buffer at the edge of acceptance.
  - A store to the same address as the pending buffer entry still drains the old value first. Net memory state is the newest data.
- Loads:
  - Latency 1: rsp_valid = 1 on the cycle after acceptance.
  - If wb_valid && wb_addr == req_addr, rsp_data = wb_data (forwarded); otherwise rsp_data = RAM[req_addr].
  - Loads never drain the buffer. Back-to-back loads keep it pending, and forwarding keeps results coherent.
- rsp_data changes only when rsp_valid = 1.
- idle = (state == RUN) && !wb_valid.
- Out-of-range addresses cannot occur, because DEPTH = 2**ADDR_W.

Decomposition:
- Shared package:
  - DATA_W and ADDR_W defaults.
  - State encoding: INIT = 1'b0, RUN = 1'b1.
  - Operation constants: OP_LOAD = 0, OP_STORE = 1.
- Sub-module spram_sync: single-port synchronous RAM with we, addr, wdata, rdata and one-cycle read latency.
- The FSM, clear counter, store buffer, arbitration and forwarding mux live in data_memory_unit.

Test Plan:
- Reset release, ADDR_W=4 -> req_ready=0 for 16 cycles, 1 on cycle 16. Loads of addresses 0..15 all return 0x00.
- Store 0xA5 to addr 0x03, load 0x03 next cycle -> rsp_valid one cycle later, rsp_data=0xA5 via forwarding. idle=0 until a non-load cycle drains the buffer.
- Store 0x11 @0x20, store 0x22 @0x21, idle cycle, then loads of 0x20 and 0x21 -> 0x11 then 0x22 on consecutive rsp_valid pulses. idle=1 after the drain.
- Two stores to 0x40 (0x01 then 0x02), then 5 back-to-back loads of 0x40 -> all return 0x02, buffer still pending. After one idle cycle, a load returns 0x02 from RAM.
- Store 0x7E @0x05, assert reset for 1 cycle before any drain -> full re-clear (req_ready low DEPTH cycles). A subsequent load of 0x05 returns 0x00.
- Reset asserted at cnt=7 during INIT -> cnt restarts at 0. req_ready rises DEPTH cycles after reset deasserts, not earlier.

Source files
------------

// File: rtl/data_memory_unit_pkg.sv
//------------------------------------------------------------------------------
// data_memory_unit_pkg
// Shared widths, FSM state encoding and operation codes for the data memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package data_memory_unit_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/data_memory_unit_spram_sync.sv
//------------------------------------------------------------------------------
// spram_sync
// Single-port synchronous RAM, one-cycle read latency, read data held on writes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spram_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end else begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/data_memory_unit.sv
//------------------------------------------------------------------------------
// data_memory_unit
// Load/store data memory with self-clear, one-entry store buffer and forwarding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              idle
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_rsp_valid;
  logic              r_fwd;
  logic [DATA_W-1:0] r_fwd_data;
  logic [DATA_W-1:0] r_hold;

  logic              w_accept, w_load, w_store, w_hit, w_drain;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  assign req_ready = (r_state == RUN);
  assign idle      = (r_state == RUN) && !r_wb_valid;
  assign w_accept  = req_valid && req_ready;
  assign w_load    = w_accept && (req_we == OP_LOAD);
  assign w_store   = w_accept && (req_we == OP_STORE);
  assign w_hit     = r_wb_valid && (r_wb_addr == req_addr);

  always_ff @(posedge clk) begin
    if (reset) r_state <= INIT;
    else       r_state <= w_state_next;
  end

  // Port arbitration: loads win, otherwise a pending store drains.
  always_comb begin
    w_state_next = r_state;
    w_ram_we     = 1'b0;
    w_ram_addr   = req_addr;
    w_ram_wdata  = r_wb_data;
    w_drain      = 1'b0;
    case (r_state)
      INIT: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_cnt;
        w_ram_wdata = '0;
        if (r_cnt == c_last_addr) w_state_next = RUN;
      end
      RUN: begin
        if (!w_load && r_wb_valid) begin
          w_ram_we   = 1'b1;
          w_ram_addr = r_wb_addr;
          w_drain    = 1'b1;
        end
      end
      default: w_state_next = INIT;
    endcase
    if (reset) w_ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_rsp_valid <= 1'b0;
      r_fwd       <= 1'b0;
      r_fwd_data  <= '0;
      r_hold      <= '0;
    end else begin
      if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
      // A same-edge store overrides the drain clear.
      if (w_drain) r_wb_valid <= 1'b0;
      if (w_store) begin
        r_wb_valid <= 1'b1;
        r_wb_addr  <= req_addr;
        r_wb_data  <= req_wdata;
      end
      r_rsp_valid <= w_load;
      if (w_load) begin
        r_fwd      <= w_hit;
        r_fwd_data <= r_wb_data;
      end
      if (r_rsp_valid) r_hold <= rsp_data;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_valid ? (r_fwd ? r_fwd_data : w_ram_rdata) : r_hold;

  spram_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_data_memory_unit.sv
//------------------------------------------------------------------------------
// tb_data_memory_unit
// Scoreboard bench: architectural memory model versus data_memory_unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_memory_unit;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              idle;

  always #5 clk = ~clk;

  data_memory_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .idle      (idle)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    time               t;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                model_pending;
  logic [DATA_W-1:0] last_data;
  int                n_checks;
  int                n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per response; response must come half a cycle after the accepting edge.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_latency", 64'($time - e.t), 64'd5);
        check("rsp_data", rsp_data, e.data);
      end
      last_data = rsp_data;
    end else begin
      check("rsp_hold", rsp_data, last_data);
      if (sb.size() > 0 && ($time - sb[0].t) > 5) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_rsp: got no response, expected 0x%0h at %0t", sb[0].data, $time);
        void'(sb.pop_front());
      end
    end
  end

  // Caller is positioned just after a rising edge; returns just after the next one.
  task automatic op(input bit v, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit   r;
    exp_t e;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    r = req_ready;
    check("idle", idle, r && !model_pending);
    @(posedge clk);
    if (r) begin
      if (v && !we) begin
        e.data = model_mem[a];
        e.t    = $time;
        sb.push_back(e);
      end else if (v && we) begin
        model_mem[a]  = d;
        model_pending = 1'b1;
      end else begin
        model_pending = 1'b0;
      end
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic apply_reset(input int hold);
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (hold) @(posedge clk);
    sb.delete();
    last_data     = '0;
    model_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    #1;
    check("reset_ready", req_ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_idle", idle, 1'b0);
  endtask

  // Releases reset and counts edges until req_ready rises.
  task automatic release_and_measure();
    int k;
    k = 0;
    reset = 1'b0;
    while (k < 2 * DEPTH) begin
      @(posedge clk);
      k++;
      #1;
      if (req_ready) break;
    end
    check("ready_latency", 64'(k), 64'(DEPTH));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_data = '0;
    apply_reset(2);
    release_and_measure();

    for (int a = 0; a < 16; a++) op(1, 0, ADDR_W'(a), '0);

    op(1, 1, 8'h03, 8'hA5);
    op(1, 0, 8'h03, 8'h00);
    op(0, 0, 8'h00, 8'h00);
    op(0, 0, 8'h00, 8'h00);

    op(1, 1, 8'h20, 8'h11);
    op(1, 1, 8'h21, 8'h22);
    op(0, 0, 8'h00, 8'h00);
    op(1, 0, 8'h20, 8'h00);
    op(1, 0, 8'h21, 8'h00);
    op(0, 0, 8'h00, 8'h00);

    op(1, 1, 8'h40, 8'h01);
    op(1, 1, 8'h40, 8'h02);
    repeat (5) op(1, 0, 8'h40, 8'h00);
    op(0, 0, 8'h00, 8'h00);
    op(1, 0, 8'h40, 8'h00);
    op(0, 0, 8'h00, 8'h00);

    op(1, 1, 8'h05, 8'h7E);
    apply_reset(1);
    release_and_measure();
    op(1, 0, 8'h05, 8'h00);
    op(0, 0, 8'h00, 8'h00);

    apply_reset(1);
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_init_ready", req_ready, 1'b0);
    apply_reset(1);
    release_and_measure();

    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      op(($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, a, DATA_W'($urandom));
    end
    repeat (3) op(0, 0, 8'h00, 8'h00);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
